mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register outputs. Sequences data-memory accesses for
//  LDR/STR/LDB/STB, plus the two-access indirect LDI/STI. Drives stall_pipeline back to all stage

---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer for LDR/STR/LDB/STB and indirect LDI/STI.
// Holds the pipeline stalled until the access completes and returns load data.
module mem_access_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             is_ldi_in,
    input  logic             is_sti_in,
    input  logic             is_ldb_stb_in,
    input  logic [15:0]      address_in,
    input  logic [15:0]      store_data_in,
    input  logic             dmem_resp,
    input  logic [15:0]      dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [15:0]      dmem_address,
    output logic [15:0]      dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output logic             stall_pipeline,
    output logic [15:0]      mem_data_out,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [15:0] ptr_reg;
    logic        req;
    logic        k_ldi;
    logic        k_sti;
    logic        k_ld;
    logic        k_st;
    logic        byte_acc;
    logic [15:0] addr_word;
    logic [1:0]  lane_be;
    logic [15:0] wdata_acc1;
    logic [15:0] ld_extract;

    // One-hot access class, highest priority first
    assign k_ldi = is_ldi_in;
    assign k_sti = !is_ldi_in && is_sti_in;
    assign k_ld  = !is_ldi_in && !is_sti_in && mem_read_in;
    assign k_st  = !is_ldi_in && !is_sti_in && !mem_read_in
                   && mem_write_in;
    assign req   = is_ldi_in | is_sti_in | mem_read_in | mem_write_in;

    assign byte_acc   = is_ldb_stb_in && (k_ld || k_st);
    assign addr_word  = {address_in[15:1], 1'b0};
    assign lane_be    = address_in[0] ? 2'b10 : 2'b01;
    assign wdata_acc1 = byte_acc
                        ? {store_data_in[7:0], store_data_in[7:0]}
                        : store_data_in;
    assign ld_extract = !is_ldb_stb_in ? dmem_rdata
                        : address_in[0] ? {8'h00, dmem_rdata[15:8]}
                        : {8'h00, dmem_rdata[7:0]};

    // Stall is suppressed while reset is held so the pipeline is released at once
    assign stall_pipeline = req && (state != DONE) && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = addr_word;
        dmem_byte_enable = 2'b11;
        dmem_wdata       = store_data_in;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = ACC1;
                end
            end
            ACC1: begin
                dmem_read  = k_ldi | k_sti | k_ld;
                dmem_write = k_st;
                dmem_wdata = wdata_acc1;
                if (byte_acc) begin
                    dmem_byte_enable = lane_be;
                end
                if (dmem_resp) begin
                    state_nx = (k_ldi || k_sti) ? ACC2 : DONE;
                end
            end
            ACC2: begin
                dmem_address = ptr_reg;
                dmem_read    = k_ldi;
                dmem_write   = k_sti;
                if (dmem_resp) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg      <= 16'h0000;
            mem_data_out <= 16'h0000;
        end else begin
            if (state == ACC1 && dmem_resp) begin
                if (k_ldi || k_sti) begin
                    ptr_reg <= {dmem_rdata[15:1], 1'b0};
                end
                if (k_ld) begin
                    mem_data_out <= ld_extract;
                end
            end
            if (state == ACC2 && dmem_resp && k_ldi) begin
                mem_data_out <= dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_pipeline && (stall_count != '1)) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vectors, reset/saturation sequences
// and randomized operations against an access-level reference model.
module tb_mem_access_unit;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             mem_read_in;
    logic             mem_write_in;
    logic             is_ldi_in;
    logic             is_sti_in;
    logic             is_ldb_stb_in;
    logic [15:0]      address_in;
    logic [15:0]      store_data_in;
    logic             dmem_resp;
    logic [15:0]      dmem_rdata;
    logic             dmem_read;
    logic             dmem_write;
    logic [15:0]      dmem_address;
    logic [15:0]      dmem_wdata;
    logic [1:0]       dmem_byte_enable;
    logic             stall_pipeline;
    logic [15:0]      mem_data_out;
    logic [CNT_W-1:0] stall_count;

    mem_access_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .is_ldi_in        (is_ldi_in),
        .is_sti_in        (is_sti_in),
        .is_ldb_stb_in    (is_ldb_stb_in),
        .address_in       (address_in),
        .store_data_in    (store_data_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall_pipeline   (stall_pipeline),
        .mem_data_out     (mem_data_out),
        .stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        ldi;
        logic        sti;
        logic        byt;
        logic [15:0] addr;
        logic [15:0] sd;
        int          dly;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] ed;
        int          es;
    } vec_t;

    int          nvec;
    int          nerr;
    int          model_cnt;
    logic [15:0] cur_data;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic ldi,
                          input logic sti, input logic byt,
                          input logic [15:0] a, input logic [15:0] sd);
        mem_read_in   = rd;
        mem_write_in  = wr;
        is_ldi_in     = ldi;
        is_sti_in     = sti;
        is_ldb_stb_in = byt;
        address_in    = a;
        store_data_in = sd;
    endtask

    // Runs one EX/MEM instruction through MEM, playing the memory with
    // dly wait cycles per access, checking every strobe cycle.
    task automatic do_op(input vec_t v);
        logic        e_wr[2];
        logic [15:0] e_ad[2];
        logic [1:0]  e_be[2];
        logic [15:0] e_wd[2];
        int          nacc;
        int          idx;
        int          wc;
        int          ncyc;
        int          nst;
        bit          done;
        bit          ind;
        bit          plain_ld;
        bit          plain_st;
        ind      = v.ldi || v.sti;
        plain_ld = !ind && v.rd;
        plain_st = !ind && !v.rd && v.wr;
        nacc = ind ? 2 : (plain_ld || plain_st) ? 1 : 0;
        e_wr[0] = plain_st;
        e_ad[0] = v.addr & 16'hFFFE;
        e_be[0] = (v.byt && !ind) ? (v.addr[0] ? 2'b10 : 2'b01) : 2'b11;
        e_wd[0] = (v.byt && !ind) ? {v.sd[7:0], v.sd[7:0]} : v.sd;
        e_wr[1] = !v.ldi;
        e_ad[1] = v.r1 & 16'hFFFE;
        e_be[1] = 2'b11;
        e_wd[1] = v.sd;
        @(posedge clk); #1;
        set_in(v.rd, v.wr, v.ldi, v.sti, v.byt, v.addr, v.sd);
        #1;
        idx  = 0;
        wc   = 0;
        ncyc = 0;
        nst  = 0;
        done = 0;
        while (!done) begin
            dmem_resp = 1'b0;
            if (dmem_read || dmem_write) begin
                if (idx >= nacc) begin
                    chk("extra_access", 32'(idx), 32'(nacc - 1));
                end else begin
                    chk("strobe_rd", 32'(dmem_read), 32'(!e_wr[idx]));
                    chk("strobe_wr", 32'(dmem_write), 32'(e_wr[idx]));
                    chk("address", 32'(dmem_address), 32'(e_ad[idx]));
                    chk("byte_en", 32'(dmem_byte_enable), 32'(e_be[idx]));
                    if (e_wr[idx]) begin
                        chk("wdata", 32'(dmem_wdata), 32'(e_wd[idx]));
                    end
                    if (wc == v.dly) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = (idx == 0) ? v.r1 : v.r2;
                        idx++;
                        wc = 0;
                    end else begin
                        wc++;
                    end
                end
            end
            #1;
            if (stall_pipeline) nst++;
            else done = 1;
            ncyc++;
            if (ncyc > 200) begin
                chk("timeout", 32'(ncyc), 32'(200));
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        dmem_resp = 1'b0;
        chk("stall_cycles", 32'(nst), 32'(v.es));
        chk("access_count", 32'(idx), 32'(nacc));
        chk("mem_data_out", 32'(mem_data_out), 32'(v.ed));
        chk("done_strobes", 32'({dmem_read, dmem_write}), 32'(0));
        model_cnt = model_cnt + v.es;
        if (model_cnt > CMAX) model_cnt = CMAX;
        chk("stall_count", 32'(stall_count), 32'(model_cnt));
        cur_data = v.ed;
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        nvec       = 0;
        nerr       = 0;
        model_cnt  = 0;
        cur_data   = 16'h0000;
        reset_n    = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        set_in(0, 0, 0, 0, 0, 16'h0000, 16'h0000);

        tbl[0]  = '{1,0,0,0,0,16'h1235,16'h0000,0,16'hBEEF,16'h0000,16'hBEEF,2};
        tbl[1]  = '{0,1,0,0,1,16'h2001,16'h00A5,0,16'h0000,16'h0000,16'hBEEF,2};
        tbl[2]  = '{1,0,0,0,1,16'h3001,16'h0000,0,16'h7F80,16'h0000,16'h007F,2};
        tbl[3]  = '{1,0,0,0,1,16'h3000,16'h0000,0,16'h7F80,16'h0000,16'h0080,2};
        tbl[4]  = '{1,0,1,0,0,16'h4000,16'h0000,0,16'h5001,16'h1111,16'h1111,3};
        tbl[5]  = '{1,1,0,1,0,16'h6002,16'h9876,3,16'h7003,16'h0000,16'h1111,9};
        tbl[6]  = '{0,1,0,0,0,16'h0101,16'hCAFE,1,16'h0000,16'h0000,16'h1111,3};
        tbl[7]  = '{0,0,0,0,1,16'h5555,16'h0000,0,16'h0000,16'h0000,16'h1111,0};
        tbl[8]  = '{1,1,1,1,1,16'h0A03,16'h4321,0,16'h0C07,16'h2222,16'h2222,3};
        tbl[9]  = '{1,1,0,0,1,16'h0E03,16'h0011,2,16'hAB12,16'h0000,16'h00AB,4};
        tbl[10] = '{1,0,0,1,1,16'h0F01,16'h00FF,0,16'h0D0D,16'h0000,16'h00AB,3};

        #12;
        chk("rst_data", 32'(mem_data_out), 32'(0));
        chk("rst_count", 32'(stall_count), 32'(0));
        chk("rst_stall", 32'(stall_pipeline), 32'(0));
        chk("rst_strobes", 32'({dmem_read, dmem_write}), 32'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i]);
        end

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            set_in(0, 0, 0, 0, i[0], 16'(i * 77), 16'(i));
            #1;
            chk("idle_stall", 32'(stall_pipeline), 32'(0));
            chk("idle_strobes", 32'({dmem_read, dmem_write}), 32'(0));
        end
        chk("idle_count", 32'(stall_count), 32'(model_cnt));

        @(posedge clk); #1;
        set_in(0, 0, 1, 0, 0, 16'h4000, 16'h0000);
        @(posedge clk); #1;
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h5001;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("acc2_read", 32'(dmem_read), 32'(1));
        chk("acc2_addr", 32'(dmem_address), 32'(16'h5000));
        reset_n = 1'b0;
        #1;
        chk("mrst_strobes", 32'({dmem_read, dmem_write}), 32'(0));
        chk("mrst_stall", 32'(stall_pipeline), 32'(0));
        chk("mrst_data", 32'(mem_data_out), 32'(0));
        chk("mrst_count", 32'(stall_count), 32'(0));
        set_in(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        model_cnt = 0;
        cur_data  = 16'h0000;

        @(posedge clk); #1;
        set_in(1, 0, 0, 0, 0, 16'h0042, 16'h0000);
        for (int i = 0; i < CMAX + 6; i++) begin
            @(posedge clk); #1;
        end
        chk("sat_count", 32'(stall_count), 32'(CMAX));
        chk("sat_hold_rd", 32'(dmem_read), 32'(1));
        chk("sat_hold_ad", 32'(dmem_address), 32'(16'h0042));
        chk("sat_stall", 32'(stall_pipeline), 32'(1));
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h3C3C;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("sat_done", 32'(stall_pipeline), 32'(0));
        chk("sat_data", 32'(mem_data_out), 32'(16'h3C3C));
        chk("sat_final", 32'(stall_count), 32'(CMAX));
        model_cnt = CMAX;
        cur_data  = 16'h3C3C;

        for (int i = 0; i < 150; i++) begin
            rv.rd   = 1'($urandom);
            rv.wr   = 1'($urandom);
            rv.ldi  = ($urandom_range(0, 5) == 0);
            rv.sti  = ($urandom_range(0, 5) == 0);
            rv.byt  = 1'($urandom);
            rv.addr = 16'($urandom);
            rv.sd   = 16'($urandom);
            rv.dly  = $urandom_range(0, 2);
            rv.r1   = 16'($urandom);
            rv.r2   = 16'($urandom);
            rv.ed   = cur_data;
            rv.es   = 0;
            if (rv.ldi) begin
                rv.ed = rv.r2;
                rv.es = 1 + 2 * (rv.dly + 1);
            end else if (rv.sti) begin
                rv.es = 1 + 2 * (rv.dly + 1);
            end else if (rv.rd) begin
                if (!rv.byt) rv.ed = rv.r1;
                else if (rv.addr[0]) rv.ed = {8'h00, rv.r1[15:8]};
                else rv.ed = {8'h00, rv.r1[7:0]};
                rv.es = 2 + rv.dly;
            end else if (rv.wr) begin
                rv.es = 2 + rv.dly;
            end
            do_op(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
